spatial_encoder: RTL and testbench

SPATIAL_ENCODER -- requirements
Module: spatial_encoder

---
 rtl/spatial_encoder.sv | 135 +++++++++++++
 tb/tb_spatial_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spatial_encoder.sv
// Spatial encoder: binds each channel's quantized level to a rotated sparse seed
// hypervector, accumulates per-bit votes across NUM_CH channels and emits a
// thresholded sample hypervector through a valid/ready output handshake.
module spatial_encoder #(
    parameter int unsigned  D          = 256,
    parameter int unsigned  NUM_CH     = 8,
    parameter int unsigned  LEVEL_STEP = 16,
    parameter int unsigned  CH_STEP    = 1,
    parameter int unsigned  THRESHOLD  = 2,
    parameter logic [D-1:0] BASE_HV    = {{(D-1){1'b0}}, 1'b1}
                                       | ({{(D-1){1'b0}}, 1'b1} << 64)
                                       | ({{(D-1){1'b0}}, 1'b1} << 128)
                                       | ({{(D-1){1'b0}}, 1'b1} << 192)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_level,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_hv,
    output logic         level_err
);

    localparam int unsigned   CntW     = $clog2(NUM_CH + 1);
    localparam int unsigned   ChW      = $clog2(NUM_CH);
    localparam logic [3:0]    MaxLevel = 4'd9;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [ChW-1:0]  LastCh = ChW'(NUM_CH - 1);

    typedef enum logic [0:0] {StAccum, StEmit} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ChW-1:0]      r_ch;
    logic [CntW-1:0]     r_votes     [D];
    logic [CntW-1:0]     w_votes_inc [D];
    logic [D-1:0]        r_hv;
    logic [D-1:0]        w_hv_next;
    logic                r_level_err;
    logic [3:0]          w_level;
    logic [31:0]         w_rot;
    logic [D-1:0]        w_bound;
    logic                w_accept;
    logic                w_last;
    logic                w_release;

    // Clamp out-of-range levels to the top quantizer level.
    assign w_level = (in_level > MaxLevel) ? MaxLevel : in_level;

    // Rotation amount for this channel/level, reduced into [0, D).
    assign w_rot = (32'(w_level) * LEVEL_STEP + 32'(r_ch) * CH_STEP) % D;

    // Left rotation; a shift by D yields zero, so rot == 0 is handled.
    assign w_bound = (BASE_HV << w_rot) | (BASE_HV >> (D - w_rot));

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_ch == LastCh);
    assign w_release = out_valid && out_ready;

    assign out_hv    = r_hv;
    assign level_err = r_level_err;

    // Next-state and handshake outputs for the ACCUM/EMIT controller.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            StAccum: begin
                in_ready = !rst;
                if (in_valid && !rst && w_last) begin
                    w_state_next = StEmit;
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StAccum;
                end
            end
            default: w_state_next = StAccum;
        endcase
    end

    // Saturating vote update and thresholded result including the current vector.
    always_comb begin
        w_hv_next = '0;
        for (int i = 0; i < D; i++) begin
            w_votes_inc[i] = r_votes[i];
            if (w_bound[i] && (r_votes[i] != CntMax)) begin
                w_votes_inc[i] = r_votes[i] + CntW'(1);
            end
            w_hv_next[i] = (32'(w_votes_inc[i]) >= THRESHOLD);
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Channel counter, vote counters, output vector and level error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_hv        <= '0;
            r_level_err <= 1'b0;
            for (int i = 0; i < D; i++) begin
                r_votes[i] <= '0;
            end
        end else begin
            r_level_err <= w_accept && (in_level > MaxLevel);
            if (w_accept) begin
                r_votes <= w_votes_inc;
                if (w_last) begin
                    r_hv <= w_hv_next;
                end else begin
                    r_ch <= r_ch + ChW'(1);
                end
            end else if (w_release) begin
                r_ch <= '0;
                for (int i = 0; i < D; i++) begin
                    r_votes[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spatial_encoder.sv
// Bench for spatial_encoder: three instances with different THRESHOLD/CH_STEP
// share one directed stimulus; a position-level model predicts every output.
module tb_spatial_encoder;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_level;
    logic         out_ready;

    logic         rdy_a, vld_a, err_a;
    logic         rdy_b, vld_b, err_b;
    logic         rdy_c, vld_c, err_c;
    logic [255:0] hv_a, hv_b, hv_c;

    logic         rdy [3];
    logic         vld [3];
    logic         err [3];
    logic [255:0] hv  [3];

    assign rdy[0] = rdy_a;  assign rdy[1] = rdy_b;  assign rdy[2] = rdy_c;
    assign vld[0] = vld_a;  assign vld[1] = vld_b;  assign vld[2] = vld_c;
    assign err[0] = err_a;  assign err[1] = err_b;  assign err[2] = err_c;
    assign hv[0]  = hv_a;   assign hv[1]  = hv_b;   assign hv[2]  = hv_c;

    spatial_encoder #(.THRESHOLD(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_level(in_level),
        .out_valid(vld_a), .out_ready(out_ready), .out_hv(hv_a), .level_err(err_a)
    );
    spatial_encoder #(.THRESHOLD(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_level(in_level),
        .out_valid(vld_b), .out_ready(out_ready), .out_hv(hv_b), .level_err(err_b)
    );
    spatial_encoder #(.THRESHOLD(2), .CH_STEP(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_level(in_level),
        .out_valid(vld_c), .out_ready(out_ready), .out_hv(hv_c), .level_err(err_c)
    );

    // Hand-computed expectations, one 64-bit word repeated since the seed has period 64.
    // All-zero levels, CH_STEP=1, THRESHOLD=1: bits {0,64,128,192}+c, c=0..7.
    localparam logic [255:0] ExpT1  = {4{64'h0000_0000_0000_00FF}};
    // All-zero levels, CH_STEP=0: every channel hits the same four bits.
    localparam logic [255:0] ExpC1  = {4{64'h0000_0000_0000_0001}};
    // ch0 level 12 (clamped to 9, rotate 144 -> bit 16 of each word), ch1..7 level 0.
    localparam logic [255:0] ExpErr = {4{64'h0000_0000_0001_00FE}};
    // Levels {3,3,0,1,2,4,5,6}, CH_STEP=0, THRESHOLD=2: levels 4..6 rotate by 64..96
    // and land on the same bits as levels 0..2, so rotations 0,16,32,48 all reach 2.
    localparam logic [255:0] Exp31  = {4{64'h0001_0001_0001_0001}};

    int checks = 0;
    int errors = 0;

    int thr   [3] = '{1, 2, 2};
    int cstep [3] = '{1, 1, 0};

    // Model state.
    bit           m_emit;
    int           m_ch;
    int           m_votes [3][256];
    logic [255:0] m_hv [3];
    bit           m_err;
    bit           m_just_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h want=%h", name, k, act, exp);
        end
    endtask

    task automatic clear_votes();
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 256; b++)
                m_votes[k][b] = 0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        if (rst) begin
            m_emit = 0;
            m_ch = 0;
            m_err = 0;
            m_just_rst = 1;
            clear_votes();
            for (int k = 0; k < 3; k++) m_hv[k] = '0;
        end else begin
            m_just_rst = 0;
            m_err = 0;
            if (!m_emit && in_valid) begin
                int lv;
                lv = (in_level > 4'd9) ? 9 : int'(in_level);
                m_err = (in_level > 4'd9);
                for (int k = 0; k < 3; k++) begin
                    int rot;
                    rot = (lv * 16 + m_ch * cstep[k]) % 256;
                    for (int p = 0; p < 4; p++) m_votes[k][(p * 64 + rot) % 256] += 1;
                end
                if (m_ch == 7) begin
                    m_emit = 1;
                    m_ch = 0;
                    for (int k = 0; k < 3; k++)
                        for (int b = 0; b < 256; b++)
                            m_hv[k][b] = (m_votes[k][b] >= thr[k]);
                end else begin
                    m_ch++;
                end
            end else if (m_emit && out_ready) begin
                m_emit = 0;
                m_ch = 0;
                clear_votes();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every instance against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, 256'(rdy[k]), 256'(!m_emit && !rst));
            chk("out_valid", k, 256'(vld[k]), 256'(m_emit));
            chk("level_err", k, 256'(err[k]), 256'(m_err));
            if (m_emit || m_just_rst) chk("out_hv", k, hv[k], m_hv[k]);
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [3:0] l, input bit ordy);
        rst = r;
        in_valid = v;
        in_level = l;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] lv [8], input bit ordy);
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, lv[c], ordy);
    endtask

    logic [3:0] lv0  [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] lv31 [8] = '{4'd3, 4'd3, 4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    logic [3:0] lva  [8] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
    logic [3:0] lvb  [8] = '{4'd15, 4'd0, 4'd10, 4'd2, 4'd9, 4'd1, 4'd13, 4'd4};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_level = 4'd0;
        out_ready = 1'b0;
        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 4'd3, 1'b1);

        // All channels at level 0, downstream stalled.
        sample(lv0, 1'b0);
        @(negedge clk);
        chk("lit_t1_hv", 0, hv_a, ExpT1);
        chk("lit_t1_pop", 0, 256'($countones(hv_a)), 256'(32));
        chk("lit_t2_hv", 1, hv_b, '0);
        chk("lit_c1_hv", 2, hv_c, ExpC1);
        chk("lit_t1_valid", 0, 256'(vld_a), 256'(1));
        #1;
        cyc(1'b0, 1'b1, 4'd5, 1'b1);

        // Out-of-range level on channel 0.
        cyc(1'b0, 1'b1, 4'd12, 1'b0);
        @(negedge clk);
        chk("lit_level_err", 0, 256'(err_a), 256'(1));
        #1;
        for (int c = 1; c < 8; c++) cyc(1'b0, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        chk("lit_err_hv", 0, hv_a, ExpErr);
        #1;

        // Stall five cycles in EMIT with in_valid asserted.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'(i + 1), 1'b0);
        @(negedge clk);
        chk("lit_hold_hv", 0, hv_a, ExpErr);
        chk("lit_hold_rdy", 0, 256'(rdy_a), 256'(0));
        #1;
        cyc(1'b0, 1'b1, 4'd3, 1'b1);

        // Shared-level vector with CH_STEP=0.
        sample(lv31, 1'b0);
        @(negedge clk);
        chk("lit_31_hv", 2, hv_c, Exp31);
        #1;
        cyc(1'b0, 1'b1, 4'd0, 1'b1);

        // Back-to-back samples at full rate.
        sample(lva, 1'b1);
        cyc(1'b0, 1'b1, 4'd7, 1'b1);
        sample(lvb, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1);

        // Reset after four channels, then a fresh all-zero sample.
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 4'd7, 1'b1);
        cyc(1'b1, 1'b1, 4'd2, 1'b1);
        sample(lv0, 1'b0);
        @(negedge clk);
        chk("lit_rst_mid_hv", 0, hv_a, ExpT1);
        chk("lit_rst_mid_c", 2, hv_c, ExpC1);
        #1;
        cyc(1'b0, 1'b0, 4'd0, 1'b1);

        // Reset while a sample is pending in EMIT.
        sample(lva, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        sample(lv0, 1'b0);
        @(negedge clk);
        chk("lit_rst_emit_hv", 0, hv_a, ExpT1);
        #1;
        cyc(1'b0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
